// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture_pkg
// Description : Shared state encodings and helpers for the PWM capture block.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        WAIT_LEAD  = 2'd0,
        MEAS_ACT   = 2'd1,
        MEAS_INACT = 2'd2
    } capt_state_t;

    localparam int c_default_dwidth      = 8;
    localparam int c_default_sync_stages = 2;

    function automatic logic is_measuring(input capt_state_t s);
        return (s == MEAS_ACT) || (s == MEAS_INACT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture_if
// Description : Control/result bundle between the register block and capture.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_capture_if #(
    parameter int APB_DWIDTH = 8
);
    logic                  enable;
    logic                  pwm_in;
    logic                  polarity;
    logic [APB_DWIDTH-1:0] prescale_reg;
    logic                  clr_ovf;
    logic [APB_DWIDTH-1:0] period_capt;
    logic [APB_DWIDTH-1:0] active_capt;
    logic                  capt_valid;
    logic                  overflow;

    modport master (
        output enable, pwm_in, polarity, prescale_reg, clr_ovf,
        input  period_capt, active_capt, capt_valid, overflow
    );

    modport slave (
        input  enable, pwm_in, polarity, prescale_reg, clr_ovf,
        output period_capt, active_capt, capt_valid, overflow
    );
endinterface
`default_nettype wire

// File: rtl/pwm_capture_sync.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture_sync
// Description : Multi-flop synchroniser for pwm_in plus rise/fall detection.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic PCLK,
    input  wire logic PRESETN,
    input  wire logic pwm_in,
    output logic      pin_s,
    output logic      rise,
    output logic      fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pin_d;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_sync  <= '0;
            r_pin_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_pin_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign pin_s = r_sync[SYNC_STAGES-1];
    assign rise  = pin_s & ~r_pin_d;
    assign fall  = ~pin_s & r_pin_d;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Measures period and active time of an external PWM input in
//               prescaled ticks and latches the results on each leading edge.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int APB_DWIDTH  = c_default_dwidth,
    parameter int SYNC_STAGES = c_default_sync_stages
) (
    input  wire logic     PCLK,
    input  wire logic     PRESETN,
    pwm_capture_if.slave  bus
);

    localparam logic [APB_DWIDTH-1:0] c_sat_max = '1;

    logic w_pin_s;
    logic w_rise;
    logic w_fall;
    logic w_on_active;
    logic w_lead;
    logic w_trail;
    logic w_tick;
    logic w_sat_tick;
    logic [APB_DWIDTH-1:0] w_incr;

    capt_state_t           r_state;
    logic [APB_DWIDTH-1:0] r_prescale_cnt;
    logic [APB_DWIDTH-1:0] r_meas_cnt;
    logic [APB_DWIDTH-1:0] r_act_hold;
    logic [APB_DWIDTH-1:0] r_period_capt;
    logic [APB_DWIDTH-1:0] r_active_capt;
    logic                  r_capt_valid;
    logic                  r_overflow;

    pwm_capture_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .pwm_in  (bus.pwm_in),
        .pin_s   (w_pin_s),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    // An edge that lands on the active level is the leading edge; otherwise trailing.
    assign w_on_active = w_pin_s ^ bus.polarity;
    assign w_lead      = (w_rise | w_fall) & w_on_active;
    assign w_trail     = (w_rise | w_fall) & ~w_on_active;

    assign w_tick     = (r_prescale_cnt >= bus.prescale_reg);
    assign w_incr     = (r_meas_cnt == c_sat_max) ? r_meas_cnt
                      : r_meas_cnt + {{(APB_DWIDTH-1){1'b0}}, w_tick};
    assign w_sat_tick = w_tick & (r_meas_cnt == c_sat_max)
                      & bus.enable & is_measuring(r_state);

    // Realigning the prescaler on the leading edge keeps tick boundaries in phase with the input.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_prescale_cnt <= '0;
        end else if ((w_lead && bus.enable) || w_tick) begin
            r_prescale_cnt <= '0;
        end else begin
            r_prescale_cnt <= r_prescale_cnt + APB_DWIDTH'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state       <= WAIT_LEAD;
            r_meas_cnt    <= '0;
            r_act_hold    <= '0;
            r_period_capt <= '0;
            r_active_capt <= '0;
            r_capt_valid  <= 1'b0;
        end else begin
            r_capt_valid <= 1'b0;
            if (!bus.enable) begin
                r_state    <= WAIT_LEAD;
                r_meas_cnt <= '0;
            end else begin
                case (r_state)
                    WAIT_LEAD: begin
                        if (w_lead) begin
                            r_state    <= MEAS_ACT;
                            r_meas_cnt <= '0;
                        end
                    end
                    MEAS_ACT: begin
                        // A second lead here means polarity was flipped mid-run: restart cleanly.
                        if (w_lead) begin
                            r_meas_cnt <= '0;
                        end else begin
                            r_meas_cnt <= w_incr;
                            if (w_trail) begin
                                r_act_hold <= w_incr;
                                r_state    <= MEAS_INACT;
                            end
                        end
                    end
                    MEAS_INACT: begin
                        if (w_lead) begin
                            r_period_capt <= w_incr;
                            r_active_capt <= r_act_hold;
                            r_capt_valid  <= 1'b1;
                            r_meas_cnt    <= '0;
                            r_state       <= MEAS_ACT;
                        end else begin
                            r_meas_cnt <= w_incr;
                        end
                    end
                    default: begin
                        r_state    <= WAIT_LEAD;
                        r_meas_cnt <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_overflow <= 1'b0;
        end else if (w_sat_tick) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.period_capt = r_period_capt;
    assign bus.active_capt = r_active_capt;
    assign bus.capt_valid  = r_capt_valid;
    assign bus.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_capture
// Description : Self-checking bench for pwm_capture using directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

    logic PCLK    = 1'b0;
    logic PRESETN = 1'b0;

    pwm_capture_if #(.APB_DWIDTH(8)) bus ();

    pwm_capture #(
        .APB_DWIDTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int   presc;
        logic pol;
        int   per;
        int   hi;
        int   exp_per;
        int   exp_act;
    } vec_t;

    vec_t vecs [7];

    int n_err   = 0;
    int n_chk   = 0;
    int n_valid = 0;
    int base;

    always @(negedge PCLK) begin
        if (bus.capt_valid === 1'b1) n_valid++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Raw waveform: rise, hi cycles high, then low; last period keeps only a short low tail.
    task automatic wave(input int per, input int hi, input int nper);
        for (int k = 0; k < nper; k++) begin
            bus.pwm_in = 1'b1;
            step(hi);
            bus.pwm_in = 1'b0;
            if (k < nper - 1) step(per - hi);
            else              step(2);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bus.enable       = 1'b0;
        bus.prescale_reg = v.presc[7:0];
        bus.polarity     = v.pol;
        step(4);
        base       = n_valid;
        bus.enable = 1'b1;
        step(3);
        wave(v.per, v.hi, 3);
        step(6);
        check($sformatf("vec%0d valid_count", idx), n_valid - base, 2);
        check($sformatf("vec%0d period_capt", idx), {24'd0, bus.period_capt}, v.exp_per);
        check($sformatf("vec%0d active_capt", idx), {24'd0, bus.active_capt}, v.exp_act);
        check($sformatf("vec%0d overflow", idx), {31'd0, bus.overflow}, 0);
        bus.enable = 1'b0;
        step(2);
    endtask

    task automatic pulse_clr();
        bus.clr_ovf = 1'b1;
        step(1);
        bus.clr_ovf = 1'b0;
    endtask

    initial begin
        vecs[0] = '{0, 1'b0,  10,  3,  10, 3};
        vecs[1] = '{1, 1'b0,  20, 10,  10, 5};
        vecs[2] = '{3, 1'b0,  40, 12,  10, 3};
        vecs[3] = '{0, 1'b1,  10,  3,  10, 7};
        vecs[4] = '{0, 1'b0, 255,  1, 255, 1};
        vecs[5] = '{2, 1'b1,  30,  9,  10, 7};
        vecs[6] = '{4, 1'b0,  25, 20,   5, 4};

        bus.enable       = 1'b0;
        bus.pwm_in       = 1'b0;
        bus.polarity     = 1'b0;
        bus.prescale_reg = 8'd0;
        bus.clr_ovf      = 1'b0;

        #23;
        check("reset period_capt", {24'd0, bus.period_capt}, 0);
        check("reset active_capt", {24'd0, bus.active_capt}, 0);
        check("reset capt_valid",  {31'd0, bus.capt_valid}, 0);
        check("reset overflow",    {31'd0, bus.overflow}, 0);
        @(posedge PCLK);
        #3 PRESETN = 1'b1;
        step(5);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Period longer than the counter range saturates and sets overflow.
        bus.prescale_reg = 8'd0;
        bus.polarity     = 1'b0;
        step(2);
        base       = n_valid;
        bus.enable = 1'b1;
        step(3);
        wave(300, 150, 3);
        step(6);
        check("sat valid_count", n_valid - base, 2);
        check("sat period_capt", {24'd0, bus.period_capt}, 255);
        check("sat active_capt", {24'd0, bus.active_capt}, 150);
        check("sat overflow",    {31'd0, bus.overflow}, 1);
        bus.enable = 1'b0;
        step(1);
        pulse_clr();
        check("sat overflow cleared", {31'd0, bus.overflow}, 0);

        // Input stuck active: no capture, overflow, clear loses to a coincident saturating tick.
        bus.enable = 1'b1;
        step(3);
        base       = n_valid;
        bus.pwm_in = 1'b1;
        step(400);
        check("stuck valid_count", n_valid - base, 0);
        check("stuck overflow",    {31'd0, bus.overflow}, 1);
        pulse_clr();
        check("stuck clr vs sat tick", {31'd0, bus.overflow}, 1);
        bus.pwm_in = 1'b0;
        step(7);
        wave(10, 3, 3);
        step(6);
        check("resume valid_count", n_valid - base, 3);
        check("resume period_capt", {24'd0, bus.period_capt}, 10);
        check("resume active_capt", {24'd0, bus.active_capt}, 3);
        bus.enable = 1'b0;
        step(1);
        pulse_clr();
        check("resume overflow cleared", {31'd0, bus.overflow}, 0);

        // Enable dropped while the input is high: nothing captured, registers hold.
        bus.enable = 1'b1;
        step(3);
        base       = n_valid;
        bus.pwm_in = 1'b1;
        step(5);
        bus.enable = 1'b0;
        step(3);
        bus.pwm_in = 1'b0;
        step(12);
        wave(20, 8, 2);
        step(6);
        check("disable valid_count", n_valid - base, 0);
        check("disable period hold", {24'd0, bus.period_capt}, 10);
        check("disable active hold", {24'd0, bus.active_capt}, 3);
        base       = n_valid;
        bus.enable = 1'b1;
        step(3);
        wave(16, 5, 3);
        step(6);
        check("reenable valid_count", n_valid - base, 2);
        check("reenable period_capt", {24'd0, bus.period_capt}, 16);
        check("reenable active_capt", {24'd0, bus.active_capt}, 5);

        // Asynchronous reset in the middle of a measurement.
        bus.pwm_in = 1'b1;
        step(8);
        @(posedge PCLK);
        #2 PRESETN = 1'b0;
        #1;
        check("async rst period_capt", {24'd0, bus.period_capt}, 0);
        check("async rst active_capt", {24'd0, bus.active_capt}, 0);
        check("async rst capt_valid",  {31'd0, bus.capt_valid}, 0);
        check("async rst overflow",    {31'd0, bus.overflow}, 0);
        bus.pwm_in = 1'b0;
        @(posedge PCLK);
        #3 PRESETN = 1'b1;
        step(6);
        base = n_valid;
        wave(10, 3, 3);
        step(6);
        check("post rst valid_count", n_valid - base, 2);
        check("post rst period_capt", {24'd0, bus.period_capt}, 10);
        check("post rst active_capt", {24'd0, bus.active_capt}, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
